// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Define UART_TX_PARITY_EN to add a parity bit and BAUDDIV[16] odd select.
module mmio_uart_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1001_0100,
  parameter int FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [ADDR_WIDTH-1:0] RWAddress,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] MemData,
  output logic                  hit,
  output logic                  tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef UART_TX_PARITY_EN
  localparam int BW = 17;
`else
  localparam int BW = 16;
`endif

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [4:0]    count;
  logic          overflow;
  logic [BW-1:0] baudDiv;
  state_t        state;
  logic [7:0]    shiftReg;
  logic [2:0]    bitIdx;
  logic [15:0]   baudCnt;
  logic          parityBit;

  logic       wrEn, rdEn;
  logic [1:0] regSel;
  logic       full, empty, busy;
  logic       push, pop, pushOk;
  logic       ovfSet, ovfClr;
  logic [15:0] period;
  logic       bitEnd;
  logic       unusedBits;

  assign hit    = RWAddress[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
  assign wrEn   = hit & MemWrite;
  assign rdEn   = hit & MemRead;
  assign regSel = RWAddress[3:2];

  assign full   = count == 5'(FIFO_DEPTH);
  assign empty  = count == 5'd0;
  assign busy   = state != IDLE;
  assign pop    = (state == IDLE) && !empty;
  assign push   = wrEn && (regSel == 2'd0);
  // A full FIFO still takes a push when the FSM frees a slot this cycle
  assign pushOk = push && (!full || pop);
  assign ovfSet = push && full && !pop;
  assign ovfClr = wrEn && (regSel == 2'd1) && WriteData[3];

  assign period = (baudDiv[15:0] == 16'd0) ? 16'd1 : baudDiv[15:0];
  assign bitEnd = baudCnt >= (period - 16'd1);

  assign unusedBits = ^{RWAddress[1:0], WriteData[DATA_WIDTH-1:BW]};

  always_comb begin
    MemData = '0;
    if (rdEn) begin
      case (regSel)
        2'd1: MemData[8:0] = {count, overflow, empty, full, busy};
        2'd2: MemData[BW-1:0] = baudDiv;
        default: MemData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk)
      fifoMem[wrPtr] <= WriteData[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      baudDiv  <= BW'(BAUD_DIV_RST);
    end else begin
      if (pushOk)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      count <= count + 5'(pushOk) - 5'(pop);
      if (ovfSet)
        overflow <= 1'b1;
      else if (ovfClr)
        overflow <= 1'b0;
      if (wrEn && (regSel == 2'd2))
        baudDiv <= WriteData[BW-1:0];
    end
  end

  // tx is registered from the current state, so it trails state by a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      shiftReg  <= '0;
      bitIdx    <= '0;
      baudCnt   <= '0;
      parityBit <= 1'b0;
    end else begin
      if (state != IDLE)
        baudCnt <= bitEnd ? 16'd0 : baudCnt + 16'd1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shiftReg  <= fifoMem[rdPtr];
            parityBit <= ^fifoMem[rdPtr];
            baudCnt   <= '0;
            state     <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bitEnd) begin
            bitIdx <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          tx <= shiftReg[0];
          if (bitEnd) begin
            shiftReg <= {1'b0, shiftReg[7:1]};
            bitIdx   <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= parityBit ^ baudDiv[16];
          if (bitEnd)
            state <= STOP;
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (bitEnd)
            state <= IDLE;
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing,
// FIFO overflow, baud edge cases and mid-frame reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1001_0100;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] RWAddress;
  logic [31:0] WriteData;
  logic [31:0] MemData;
  logic        hit;
  logic        tx;

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0] frameBytes [8];
  int         nFrames;
  logic       oddSel = 1'b0;

  mmio_uart_tx dut (
    .clk(clk),
    .rst(rst),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .RWAddress(RWAddress),
    .WriteData(WriteData),
    .MemData(MemData),
    .hit(hit),
    .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    MemWrite  = 1'b1;
    RWAddress = addr;
    WriteData = data;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    MemRead   = 1'b1;
    RWAddress = addr;
    #1;
    data      = MemData;
    MemRead   = 1'b0;
  endtask

  // c is the cycle index after the TXDATA write edge; s is the first low cycle
  function automatic logic expTx(int c, int s, int p);
    int rel, len, k, r, b;
    len = NB * p + 1;
    if (c < s) return 1'b1;
    rel = c - s;
    k = rel / len;
    r = rel % len;
    if (k >= nFrames) return 1'b1;
    if (r >= NB * p) return 1'b1;
    b = r / p;
    if (b == 0) return 1'b0;
    if (b <= 8) return frameBytes[k][b-1];
    if (NB == 11 && b == 9) return (^frameBytes[k]) ^ oddSel;
    return 1'b1;
  endfunction

  function automatic logic expBusy(int c, int s, int p);
    int rel, len, k;
    len = NB * p + 1;
    rel = c - (s - 1);
    if (rel < 0) return 1'b0;
    k = rel / len;
    if (k >= nFrames) return 1'b0;
    return (rel % len) < NB * p;
  endfunction

  task automatic runFrame(input string tag, input int s, input int p,
                          input int nCyc, input bit doBusy);
    logic b;
    for (int c = 0; c < nCyc; c++) begin
      @(negedge clk);
      checkEq($sformatf("%s tx c%0d", tag, c), 32'(tx), 32'(expTx(c, s, p)));
      if (doBusy) begin
        MemRead   = 1'b1;
        RWAddress = BASE + 32'h4;
        #1;
        b         = MemData[0];
        MemRead   = 1'b0;
        checkEq($sformatf("%s busy c%0d", tag, c), 32'(b),
                32'(expBusy(c, s, p)));
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    rst       = 1'b1;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    RWAddress = '0;
    WriteData = '0;
    repeat (3) @(posedge clk);
    #1;
    checkEq("reset tx", 32'(tx), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      RWAddress = BASE + 32'(i * 4);
      #1;
      checkEq($sformatf("hit +%0d", i * 4), 32'(hit), 32'h1);
    end
    RWAddress = BASE + 32'h10;
    #1;
    checkEq("hit +0x10", 32'(hit), 32'h0);
    RWAddress = BASE - 32'h4;
    #1;
    checkEq("hit -4", 32'(hit), 32'h0);

    busRead(BASE + 32'h4, rd);
    checkEq("reset status", rd, 32'h4);
    busRead(BASE + 32'h8, rd);
    checkEq("reset bauddiv", rd, 32'd434);
    busRead(BASE + 32'h0, rd);
    checkEq("txdata read", rd, 32'h0);
    busRead(BASE + 32'hC, rd);
    checkEq("reserved read", rd, 32'h0);
    busRead(BASE + 32'h18, rd);
    checkEq("miss read", rd, 32'h0);
    @(negedge clk);
    RWAddress = BASE + 32'h8;
    #1;
    checkEq("no-read memdata", MemData, 32'h0);

    // Single frame, P=4
    busWrite(BASE + 32'h8, 32'd4);
    busRead(BASE + 32'h8, rd);
    checkEq("bauddiv 4", rd, 32'd4);
    busWrite(BASE + 32'hC, 32'hFFFF_FFFF);
    busWrite(BASE + 32'h8, 32'd4);
    nFrames = 1;
    frameBytes[0] = 8'hA5;
    busWrite(BASE, 32'hA5);
    runFrame("a5", 2, 4, NB * 4 + 4, 1'b1);
    busRead(BASE + 32'h4, rd);
    checkEq("a5 status end", rd, 32'h4);

    // Burst of six writes into a 4-deep FIFO, P=1
    busWrite(BASE + 32'h8, 32'd1);
    nFrames = 5;
    for (int i = 0; i < 5; i++)
      frameBytes[i] = 8'(8'h11 * (i + 1));
    fork
      begin
        @(posedge clk);
        runFrame("burst", 2, 1, 2 + 5 * (NB + 1) + 2, 1'b0);
      end
      begin
        logic [31:0] st;
        for (int i = 0; i < 6; i++)
          busWrite(BASE, 32'(8'h11 * (i + 1)));
        busRead(BASE + 32'h4, st);
        checkEq("burst status ovf", st, 32'h4B);
        busWrite(BASE + 32'h4, 32'h8);
        busRead(BASE + 32'h4, st);
        checkEq("burst status clr", st, 32'h43);
      end
    join
    busRead(BASE + 32'h4, rd);
    checkEq("burst status end", rd, 32'h4);

    // BAUDDIV=0 behaves as P=1
    busWrite(BASE + 32'h8, 32'd0);
    nFrames = 1;
    frameBytes[0] = 8'h96;
    busWrite(BASE, 32'h96);
    runFrame("p0", 2, 1, NB + 4, 1'b1);

    // BAUDDIV 100 -> 2 while the start bit counter sits at 50
    busWrite(BASE + 32'h8, 32'd100);
    frameBytes[0] = 8'h3C;
    busWrite(BASE, 32'h3C);
    fork
      begin
        logic e;
        for (int c = 0; c < 52 + NB * 2 + 3; c++) begin
          @(negedge clk);
          if (c >= 2 && c < 54) e = 1'b0;
          else e = expTx(c, 52, 2);
          checkEq($sformatf("rebaud tx c%0d", c), 32'(tx), 32'(e));
        end
      end
      begin
        repeat (51) @(posedge clk);
        busWrite(BASE + 32'h8, 32'd2);
      end
    join

    // Reset in the middle of data bit 3
    busWrite(BASE + 32'h8, 32'd4);
    frameBytes[0] = 8'hA5;
    busWrite(BASE, 32'hA5);
    for (int c = 0; c < 20; c++)
      @(negedge clk);
    checkEq("pre-reset tx bit3", 32'(tx), 32'h0);
    #1;
    rst = 1'b1;
    #1;
    checkEq("async reset tx", 32'(tx), 32'h1);
    busRead(BASE + 32'h4, rd);
    checkEq("mid reset status", rd, 32'h4);
    busRead(BASE + 32'h8, rd);
    checkEq("mid reset bauddiv", rd, 32'd434);
    @(negedge clk);
    rst = 1'b0;
    busWrite(BASE + 32'h8, 32'd3);
    frameBytes[0] = 8'h5A;
    busWrite(BASE, 32'h5A);
    runFrame("post", 2, 3, NB * 3 + 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
